dmem_port_arbiter: RTL and testbench

Shares the single data-memory port of the single-cycle RISC-V core between two requesters: the core's load/store path and a debug/loader port used to preload or inspect data memory. Grants are resolved every cycle by a round-robin with a bounded lock. The memory sees at most one access per cycle. When the core loses arbitration it is held through `core_stall`, so no core access is lost. The block sits between the core's ALU-address/rs2-data path and D_MEM, and drives D_MEM's `MemRW`, address and write-data inputs.

---
 rtl/dmem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter with bounded debug lock that shares the single D_MEM port between the core and a debug/loader port.
// Optional statistics counters are built only when the DMEM_ARB_STATS_EN macro is defined.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
`ifdef DMEM_ARB_STATS_EN
  ,
  parameter int unsigned STAT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_MemRW,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_conflicts,
  output logic [STAT_W-1:0] stat_core_stalls
`endif
);

  localparam int unsigned HOLD_W   = 4;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_DBG  = 1'b1;

  logic              last_owner;
  logic [HOLD_W-1:0] hold_cnt;

  logic contested;
  logic pick_dbg;
  logic gnt_core;
  logic gnt_dbg;

  // Grant decision. The lock only extends ownership that debug actually won in a
  // contest (hold_cnt != 0), so reset clears a burst and the core wins next.
  always_comb begin
    contested = core_req & dbg_req;
    pick_dbg  = 1'b0;
    if (contested) begin
      if (hold_cnt == HOLD_MAX) begin
        pick_dbg = ~last_owner;
      end else if ((last_owner == OWNER_DBG) && (hold_cnt != '0) && dbg_lock) begin
        pick_dbg = 1'b1;
      end else begin
        pick_dbg = ~last_owner;
      end
    end else begin
      pick_dbg = dbg_req;
    end
    gnt_core = ~rst & core_req & ~pick_dbg;
    gnt_dbg  = ~rst & dbg_req & pick_dbg;
  end

  // Memory port steering and read-data return.
  always_comb begin
    core_gnt       = gnt_core;
    dbg_gnt        = gnt_dbg;
    core_stall     = ~rst & core_req & ~gnt_core;
    mem_MemRW      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    core_rdata     = '0;
    dbg_rdata      = '0;
    if (gnt_core) begin
      mem_MemRW      = core_we;
      mem_addr       = core_addr;
      mem_write_data = core_wdata;
      core_rdata     = mem_read_data;
    end else if (gnt_dbg) begin
      mem_MemRW      = dbg_we;
      mem_addr       = dbg_addr;
      mem_write_data = dbg_wdata;
      dbg_rdata      = mem_read_data;
    end
  end

  // Ownership and hold-count tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWNER_DBG;
      hold_cnt   <= '0;
    end else if (gnt_core | gnt_dbg) begin
      last_owner <= gnt_dbg ? OWNER_DBG : OWNER_CORE;
      if (!contested) begin
        hold_cnt <= '0;
      end else if (gnt_dbg == last_owner) begin
        if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end else begin
        hold_cnt <= HOLD_W'(1);
      end
    end else begin
      hold_cnt <= '0;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Free-running, wrapping event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflicts   <= '0;
      stat_core_stalls <= '0;
    end else begin
      if (contested) begin
        stat_conflicts <= stat_conflicts + STAT_W'(1);
      end
      if (core_stall) begin
        stat_core_stalls <= stat_core_stalls + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a behavioural asynchronous-read D_MEM.
// Stats checks are compiled in when DMEM_ARB_STATS_EN is defined.
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_req, core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt, core_stall;
  logic [DATA_W-1:0] core_rdata;
  logic              dbg_req, dbg_we, dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_MemRW;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]       stat_conflicts, stat_core_stalls;
`endif

  int tests = 0;
  int fails = 0;
  int wr_count = 0;

  logic [DATA_W-1:0] mem [0:63];

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .mem_MemRW(mem_MemRW), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
`ifdef DMEM_ARB_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_core_stalls(stat_core_stalls)
`endif
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_MemRW) begin
      mem[mem_addr[7:2]] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
  endtask

  task automatic apply_reset();
    rst = 1; set_idle();
    step();
    rst = 0;
  endtask

  task automatic dbg_load(input logic [ADDR_W-1:0] a);
    set_idle(); dbg_req = 1; dbg_addr = a;
  endtask

  task automatic test_reset();
    rst = 1;
    core_req = 1; core_we = 1; core_addr = 32'h40; core_wdata = 32'h55;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h44; dbg_wdata = 32'h66; dbg_lock = 1;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b0) begin fails++; $display("FAIL rst_core_gnt: got %b expected 0", core_gnt); end
    tests++; if (dbg_gnt !== 1'b0) begin fails++; $display("FAIL rst_dbg_gnt: got %b expected 0", dbg_gnt); end
    tests++; if (mem_MemRW !== 1'b0) begin fails++; $display("FAIL rst_memrw: got %b expected 0", mem_MemRW); end
    tests++; if (core_stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b expected 0", core_stall); end
    tests++; if (core_rdata !== '0 || dbg_rdata !== '0) begin fails++; $display("FAIL rst_rdata: got %h/%h expected 0/0", core_rdata, dbg_rdata); end
    step();
    rst = 0; set_idle();
    @(negedge clk);
    tests++; if (core_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin fails++; $display("FAIL idle_gnt: got %b%b expected 00", core_gnt, dbg_gnt); end
    tests++; if (mem_addr !== '0 || mem_write_data !== '0 || mem_MemRW !== 1'b0) begin fails++; $display("FAIL idle_mem: got %h/%h/%b expected 0/0/0", mem_addr, mem_write_data, mem_MemRW); end
`ifdef DMEM_ARB_STATS_EN
    tests++; if (stat_conflicts !== 16'd0 || stat_core_stalls !== 16'd0) begin fails++; $display("FAIL rst_stats: got %0d/%0d expected 0/0", stat_conflicts, stat_core_stalls); end
`endif
    step();
    dbg_load(32'h40);
    @(negedge clk);
    tests++; if (dbg_rdata !== 32'h0) begin fails++; $display("FAIL rst_write_dropped_core: got %h expected 0", dbg_rdata); end
    step();
    dbg_load(32'h44);
    @(negedge clk);
    tests++; if (dbg_rdata !== 32'h0) begin fails++; $display("FAIL rst_write_dropped_dbg: got %h expected 0", dbg_rdata); end
    step();
  endtask

  task automatic test_store_load();
    apply_reset();
    set_idle(); core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1 || core_stall !== 1'b0) begin fails++; $display("FAIL st_core_gnt_stall: got %b/%b expected 1/0", core_gnt, core_stall); end
    tests++; if (mem_MemRW !== 1'b1 || mem_addr !== 32'h10 || mem_write_data !== 32'hDEADBEEF) begin fails++; $display("FAIL st_mem_drive: got %b/%h/%h expected 1/10/deadbeef", mem_MemRW, mem_addr, mem_write_data); end
    step();
    dbg_load(32'h10);
    @(negedge clk);
    tests++; if (dbg_gnt !== 1'b1 || core_gnt !== 1'b0) begin fails++; $display("FAIL ld_dbg_gnt: got %b/%b expected 1/0", dbg_gnt, core_gnt); end
    tests++; if (dbg_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL ld_dbg_rdata: got %h expected deadbeef", dbg_rdata); end
    tests++; if (core_rdata !== 32'h0 || mem_MemRW !== 1'b0) begin fails++; $display("FAIL ld_core_rdata_memrw: got %h/%b expected 0/0", core_rdata, mem_MemRW); end
    step();
  endtask

  task automatic test_alternate();
    logic [3:0] exp_dbg;
    exp_dbg = 4'b1010;
    apply_reset();
    set_idle();
    core_req = 1; core_addr = 32'h10; dbg_req = 1; dbg_addr = 32'h14; dbg_lock = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (dbg_gnt !== exp_dbg[i] || core_gnt !== !exp_dbg[i]) begin fails++; $display("FAIL alt_gnt[%0d]: got core=%b dbg=%b expected dbg=%b", i, core_gnt, dbg_gnt, exp_dbg[i]); end
      tests++; if (core_stall !== exp_dbg[i]) begin fails++; $display("FAIL alt_stall[%0d]: got %b expected %b", i, core_stall, exp_dbg[i]); end
      tests++; if (mem_addr !== (exp_dbg[i] ? 32'h14 : 32'h10)) begin fails++; $display("FAIL alt_addr[%0d]: got %h expected %h", i, mem_addr, exp_dbg[i] ? 32'h14 : 32'h10); end
      step();
    end
    set_idle();
    @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
    tests++; if (stat_conflicts !== 16'd4 || stat_core_stalls !== 16'd2) begin fails++; $display("FAIL alt_stats: got %0d/%0d expected 4/2", stat_conflicts, stat_core_stalls); end
`endif
    tests++; if (core_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin fails++; $display("FAIL alt_idle: got %b%b expected 00", core_gnt, dbg_gnt); end
    step();
  endtask

  task automatic test_lock_burst();
    logic [10:0] exp_dbg;
    logic        store_done;
    int          wr_base;
    exp_dbg    = 11'b01111011110;
    store_done = 1'b0;
    apply_reset();
    wr_base = wr_count;
    for (int i = 0; i < 11; i++) begin
      set_idle();
      dbg_req = 1; dbg_lock = 1; dbg_addr = 32'h30;
      core_req = 1;
      if (i > 0 && !store_done) begin
        core_we = 1; core_addr = 32'h30; core_wdata = 32'hA5A5A5A5;
      end
      @(negedge clk);
      tests++; if (dbg_gnt !== exp_dbg[i] || core_gnt !== !exp_dbg[i]) begin fails++; $display("FAIL lock_gnt[%0d]: got core=%b dbg=%b expected dbg=%b", i, core_gnt, dbg_gnt, exp_dbg[i]); end
      tests++; if (core_stall !== exp_dbg[i]) begin fails++; $display("FAIL lock_stall[%0d]: got %b expected %b", i, core_stall, exp_dbg[i]); end
      if (exp_dbg[i]) begin
        tests++; if (dbg_rdata !== (store_done ? 32'hA5A5A5A5 : 32'h0)) begin fails++; $display("FAIL lock_rdata[%0d]: got %h expected %h", i, dbg_rdata, store_done ? 32'hA5A5A5A5 : 32'h0); end
        tests++; if (mem_MemRW !== 1'b0) begin fails++; $display("FAIL lock_stalled_write[%0d]: got %b expected 0", i, mem_MemRW); end
      end
      if (i > 0 && !exp_dbg[i]) store_done = 1'b1;
      step();
    end
    tests++; if (wr_count - wr_base !== 1) begin fails++; $display("FAIL lock_write_once: got %0d expected 1", wr_count - wr_base); end
    dbg_load(32'h30);
    @(negedge clk);
    tests++; if (dbg_rdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL lock_final: got %h expected a5a5a5a5", dbg_rdata); end
    step();
  endtask

  task automatic test_stalled_store();
    apply_reset();
    set_idle(); core_req = 1; dbg_req = 1;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1) begin fails++; $display("FAIL ss_first_core: got %b expected 1", core_gnt); end
    step();
    set_idle();
    core_req = 1; core_we = 1; core_addr = 32'h20; core_wdata = 32'h1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h2;
    @(negedge clk);
    tests++; if (dbg_gnt !== 1'b1 || core_stall !== 1'b1) begin fails++; $display("FAIL ss_dbg_wins: got gnt=%b stall=%b expected 1/1", dbg_gnt, core_stall); end
    tests++; if (mem_write_data !== 32'h2) begin fails++; $display("FAIL ss_wdata_during_stall: got %h expected 2", mem_write_data); end
    step();
    dbg_req = 0; dbg_we = 0;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1 || mem_MemRW !== 1'b1 || mem_write_data !== 32'h1) begin fails++; $display("FAIL ss_core_store: got %b/%b/%h expected 1/1/1", core_gnt, mem_MemRW, mem_write_data); end
    step();
    dbg_load(32'h20);
    @(negedge clk);
    tests++; if (dbg_rdata !== 32'h1) begin fails++; $display("FAIL ss_final: got %h expected 1", dbg_rdata); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_idle(); core_req = 1; dbg_req = 1; dbg_lock = 1;
      step();
    end
    rst = 1;
    core_req = 1; core_we = 1; core_addr = 32'h54; core_wdata = 32'h88;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h50; dbg_wdata = 32'h77; dbg_lock = 1;
    @(negedge clk);
    tests++; if (mem_MemRW !== 1'b0 || dbg_gnt !== 1'b0 || core_gnt !== 1'b0) begin fails++; $display("FAIL mid_rst_drive: got %b/%b/%b expected 0/0/0", mem_MemRW, dbg_gnt, core_gnt); end
    step();
    rst = 0;
    set_idle(); core_req = 1; dbg_req = 1; dbg_lock = 1;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin fails++; $display("FAIL mid_rst_core_first: got core=%b dbg=%b expected 1/0", core_gnt, dbg_gnt); end
`ifdef DMEM_ARB_STATS_EN
    tests++; if (stat_conflicts !== 16'd0 || stat_core_stalls !== 16'd0) begin fails++; $display("FAIL mid_rst_stats: got %0d/%0d expected 0/0", stat_conflicts, stat_core_stalls); end
`endif
    step();
    dbg_load(32'h50);
    @(negedge clk);
    tests++; if (dbg_rdata !== 32'h0) begin fails++; $display("FAIL mid_rst_dbg_dropped: got %h expected 0", dbg_rdata); end
    step();
    dbg_load(32'h54);
    @(negedge clk);
    tests++; if (dbg_rdata !== 32'h0) begin fails++; $display("FAIL mid_rst_core_dropped: got %h expected 0", dbg_rdata); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1;
    set_idle();
    step();
    step();
    test_reset();
    test_store_load();
    test_alternate();
    test_lock_burst();
    test_stalled_store();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
